// File: rtl/servant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servant_pkg
// Brief    : Shared owner/state encodings for the servant RAM arbiter.
// Revision : 1.0
// ============================================================================
package servant_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IBUS = 2'd1;
    localparam logic [1:0] OWN_DBUS = 2'd2;
    localparam logic [1:0] OWN_SBUS = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Read data returned to a requester whose transaction was killed by the watchdog
    localparam logic [31:0] TIMEOUT_FILL = 32'h0;

endpackage : servant_pkg
`default_nettype wire

// File: rtl/servant_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : servant_rr_pick
// Brief    : Combinational 3-way rotating priority picker returning an owner code.
// Revision : 1.0
// ============================================================================
module servant_rr_pick
    import servant_pkg::*;
#(
    parameter bit FIXED = 1'b0
) (
    input  logic [2:0] i_req,    // {sbus, dbus, ibus}
    input  logic [1:0] i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = OWN_NONE;
        if (FIXED) begin
            if      (i_req[2]) o_grant = OWN_SBUS;
            else if (i_req[1]) o_grant = OWN_DBUS;
            else if (i_req[0]) o_grant = OWN_IBUS;
        end else begin
            // Search begins just after the last completed owner; none/sbus both restart at ibus
            case (i_last)
                OWN_IBUS: begin
                    if      (i_req[1]) o_grant = OWN_DBUS;
                    else if (i_req[2]) o_grant = OWN_SBUS;
                    else if (i_req[0]) o_grant = OWN_IBUS;
                end
                OWN_DBUS: begin
                    if      (i_req[2]) o_grant = OWN_SBUS;
                    else if (i_req[0]) o_grant = OWN_IBUS;
                    else if (i_req[1]) o_grant = OWN_DBUS;
                end
                default: begin
                    if      (i_req[0]) o_grant = OWN_IBUS;
                    else if (i_req[1]) o_grant = OWN_DBUS;
                    else if (i_req[2]) o_grant = OWN_SBUS;
                end
            endcase
        end
    end

endmodule : servant_rr_pick
`default_nettype wire

// File: rtl/servant_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : servant_ram_arbiter
// Brief    : Registered Wishbone arbiter sharing the servant RAM between ibus,
//            dbus and the debug system bus, with a hung-slave watchdog.
// Revision : 1.0
// ============================================================================
module servant_ram_arbiter
    import servant_pkg::*;
#(
    parameter string PRIO_MODE = "RR",
    parameter int    TIMEOUT   = 1023,
    parameter int    TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    input  logic [31:0] i_sbus_adr,
    input  logic [31:0] i_sbus_dat,
    input  logic [3:0]  i_sbus_sel,
    input  logic        i_sbus_we,
    input  logic        i_sbus_cyc,
    output logic [31:0] o_sbus_rdt,
    output logic        o_sbus_ack,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    output logic [3:0]  o_mem_sel,
    output logic        o_mem_we,
    output logic        o_mem_cyc,
    input  logic [31:0] i_mem_rdt,
    input  logic        i_mem_ack,
    output logic [1:0]  o_owner,
    output logic        o_timeout
);

    localparam bit c_fixed = (PRIO_MODE == "FIXED");

    logic [0:0]    r_state;
    logic [1:0]    r_owner;
    logic [1:0]    r_last;
    logic [TW-1:0] r_cnt;

    logic [2:0] w_req;
    logic [1:0] w_last;
    logic [1:0] w_pick;
    logic       w_busy;
    logic       w_own_cyc;
    logic       w_ack;
    logic       w_to;
    logic       w_end;

    assign w_req  = {i_sbus_cyc, i_dbus_cyc, i_ibus_cyc};
    assign w_last = c_fixed ? OWN_NONE : r_last;

    servant_rr_pick #(
        .FIXED (c_fixed)
    ) u_pick (
        .i_req   (w_req),
        .i_last  (w_last),
        .o_grant (w_pick)
    );

    always_comb begin
        w_own_cyc = 1'b0;
        o_mem_adr = 32'h0;
        o_mem_dat = 32'h0;
        o_mem_sel = 4'h0;
        o_mem_we  = 1'b0;
        case (r_owner)
            OWN_IBUS: begin
                w_own_cyc = i_ibus_cyc;
                o_mem_adr = i_ibus_adr;
                o_mem_sel = 4'hF;
            end
            OWN_DBUS: begin
                w_own_cyc = i_dbus_cyc;
                o_mem_adr = i_dbus_adr;
                o_mem_dat = i_dbus_dat;
                o_mem_sel = i_dbus_sel;
                o_mem_we  = i_dbus_we;
            end
            OWN_SBUS: begin
                w_own_cyc = i_sbus_cyc;
                o_mem_adr = i_sbus_adr;
                o_mem_dat = i_sbus_dat;
                o_mem_sel = i_sbus_sel;
                o_mem_we  = i_sbus_we;
            end
            default: ;
        endcase
    end

    assign w_busy = (r_state == ST_BUSY);
    assign w_ack  = w_busy & i_mem_ack;

    // A real ack in the deadline cycle always beats the watchdog
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign w_to = w_busy & w_own_cyc & ~i_mem_ack & (r_cnt == TW'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign w_to = 1'b0;
        end
    endgenerate

    assign w_end     = w_ack | w_to;
    assign o_mem_cyc = w_busy & w_own_cyc & ~w_to;
    assign o_timeout = w_to;
    assign o_owner   = r_owner;

    assign o_ibus_ack = w_end & (r_owner == OWN_IBUS);
    assign o_dbus_ack = w_end & (r_owner == OWN_DBUS);
    assign o_sbus_ack = w_end & (r_owner == OWN_SBUS);

    assign o_ibus_rdt = (r_owner != OWN_IBUS) ? 32'h0 : (w_to ? TIMEOUT_FILL : i_mem_rdt);
    assign o_dbus_rdt = (r_owner != OWN_DBUS) ? 32'h0 : (w_to ? TIMEOUT_FILL : i_mem_rdt);
    assign o_sbus_rdt = (r_owner != OWN_SBUS) ? 32'h0 : (w_to ? TIMEOUT_FILL : i_mem_rdt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_last  <= OWN_NONE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick != OWN_NONE) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_pick;
                    end
                end
                default: begin
                    // Aborts return to IDLE without moving the rotation pointer
                    if (w_end || !w_own_cyc) begin
                        r_state <= ST_IDLE;
                        r_owner <= OWN_NONE;
                        r_cnt   <= '0;
                        if (w_end) r_last <= r_owner;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule : servant_ram_arbiter
`default_nettype wire

// File: tb/tb_servant_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_servant_ram_arbiter
// Brief    : Scoreboard bench for servant_ram_arbiter; instance 0 runs RR with
//            an 8-cycle watchdog, instance 1 runs FIXED priority.
// Revision : 1.0
// ============================================================================
module tb_servant_ram_arbiter;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_I    = 2'd1;
    localparam logic [1:0] P_D    = 2'd2;
    localparam logic [1:0] P_S    = 2'd3;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] rdt;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;

    logic [31:0] ibus_adr [2];
    logic        ibus_cyc [2];
    logic [31:0] ibus_rdt [2];
    logic        ibus_ack [2];
    logic [31:0] dbus_adr [2];
    logic [31:0] dbus_dat [2];
    logic [3:0]  dbus_sel [2];
    logic        dbus_we  [2];
    logic        dbus_cyc [2];
    logic [31:0] dbus_rdt [2];
    logic        dbus_ack [2];
    logic [31:0] sbus_adr [2];
    logic [31:0] sbus_dat [2];
    logic [3:0]  sbus_sel [2];
    logic        sbus_we  [2];
    logic        sbus_cyc [2];
    logic [31:0] sbus_rdt [2];
    logic        sbus_ack [2];
    logic [31:0] mem_adr  [2];
    logic [31:0] mem_dat  [2];
    logic [3:0]  mem_sel  [2];
    logic        mem_we   [2];
    logic        mem_cyc  [2];
    logic [31:0] mem_rdt  [2];
    logic        mem_ack  [2];
    logic [1:0]  owner    [2];
    logic        timeout  [2];
    logic        ram_en   [2];

    exp_t sb0 [$];
    exp_t sb1 [$];
    int   n_cmp = 0;
    int   n_err = 0;

    servant_ram_arbiter #(.PRIO_MODE("RR"), .TIMEOUT(8)) u_rr (
        .i_clk(clk), .i_rst(rst),
        .i_ibus_adr(ibus_adr[0]), .i_ibus_cyc(ibus_cyc[0]),
        .o_ibus_rdt(ibus_rdt[0]), .o_ibus_ack(ibus_ack[0]),
        .i_dbus_adr(dbus_adr[0]), .i_dbus_dat(dbus_dat[0]), .i_dbus_sel(dbus_sel[0]),
        .i_dbus_we(dbus_we[0]), .i_dbus_cyc(dbus_cyc[0]),
        .o_dbus_rdt(dbus_rdt[0]), .o_dbus_ack(dbus_ack[0]),
        .i_sbus_adr(sbus_adr[0]), .i_sbus_dat(sbus_dat[0]), .i_sbus_sel(sbus_sel[0]),
        .i_sbus_we(sbus_we[0]), .i_sbus_cyc(sbus_cyc[0]),
        .o_sbus_rdt(sbus_rdt[0]), .o_sbus_ack(sbus_ack[0]),
        .o_mem_adr(mem_adr[0]), .o_mem_dat(mem_dat[0]), .o_mem_sel(mem_sel[0]),
        .o_mem_we(mem_we[0]), .o_mem_cyc(mem_cyc[0]),
        .i_mem_rdt(mem_rdt[0]), .i_mem_ack(mem_ack[0]),
        .o_owner(owner[0]), .o_timeout(timeout[0])
    );

    servant_ram_arbiter #(.PRIO_MODE("FIXED"), .TIMEOUT(1023)) u_fx (
        .i_clk(clk), .i_rst(rst),
        .i_ibus_adr(ibus_adr[1]), .i_ibus_cyc(ibus_cyc[1]),
        .o_ibus_rdt(ibus_rdt[1]), .o_ibus_ack(ibus_ack[1]),
        .i_dbus_adr(dbus_adr[1]), .i_dbus_dat(dbus_dat[1]), .i_dbus_sel(dbus_sel[1]),
        .i_dbus_we(dbus_we[1]), .i_dbus_cyc(dbus_cyc[1]),
        .o_dbus_rdt(dbus_rdt[1]), .o_dbus_ack(dbus_ack[1]),
        .i_sbus_adr(sbus_adr[1]), .i_sbus_dat(sbus_dat[1]), .i_sbus_sel(sbus_sel[1]),
        .i_sbus_we(sbus_we[1]), .i_sbus_cyc(sbus_cyc[1]),
        .o_sbus_rdt(sbus_rdt[1]), .o_sbus_ack(sbus_ack[1]),
        .o_mem_adr(mem_adr[1]), .o_mem_dat(mem_dat[1]), .o_mem_sel(mem_sel[1]),
        .o_mem_we(mem_we[1]), .o_mem_cyc(mem_cyc[1]),
        .i_mem_rdt(mem_rdt[1]), .i_mem_ack(mem_ack[1]),
        .o_owner(owner[1]), .o_timeout(timeout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: classic servant RAM ack one cycle after cyc; read data = address + 0x13
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) mem_ack[k] <= 1'b0;
            else     mem_ack[k] <= ram_en[k] & mem_cyc[k] & ~mem_ack[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) mem_rdt[k] = mem_adr[k] + 32'h13;
    end

    function automatic int qsize(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic push(input int k, input logic [1:0] who, input logic [31:0] rdt, input logic to);
        exp_t e;
        e = '{who: who, rdt: rdt, to: to};
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k, input int budget);
        int n;
        n = 0;
        #1;
        while (qsize(k) != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("drain%0d_pending", k), qsize(k), 0);
    endtask

    // Monitor: every ack pulse pops one expectation from that instance's queue
    always @(negedge clk) begin : mon
        logic [2:0]  acks;
        logic [1:0]  who;
        logic [31:0] rd;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            acks = {sbus_ack[k], dbus_ack[k], ibus_ack[k]};
            case (acks)
                3'b001:  begin who = P_I;    rd = ibus_rdt[k]; end
                3'b010:  begin who = P_D;    rd = dbus_rdt[k]; end
                3'b100:  begin who = P_S;    rd = sbus_rdt[k]; end
                default: begin who = P_NONE; rd = 32'h0;       end
            endcase
            if (acks != 3'b000) begin
                n_cmp++;
                if (qsize(k) == 0) begin
                    n_err++;
                    $display("FAIL sb%0d_unexpected_ack: got acks=%b rdt=0x%0h to=%b, want no ack",
                             k, acks, rd, timeout[k]);
                end else begin
                    if (k == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    if (who !== e.who || rd !== e.rdt || timeout[k] !== e.to) begin
                        n_err++;
                        $display("FAIL sb%0d_ack: got port=%0d rdt=0x%0h to=%b, want port=%0d rdt=0x%0h to=%b",
                                 k, who, rd, timeout[k], e.who, e.rdt, e.to);
                    end
                end
            end else if (timeout[k] !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb%0d_timeout_no_ack: got timeout=%b, want 0", k, timeout[k]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_watchdog: got no finish, want finish before 100000ns");
        $fatal(1);
    end

    initial begin
        logic [1:0] rr_tbl [18];
        rr_tbl = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3,
                   2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3};

        for (int k = 0; k < 2; k++) begin
            ibus_adr[k] = '0; ibus_cyc[k] = 1'b0;
            dbus_adr[k] = '0; dbus_dat[k] = '0; dbus_sel[k] = 4'hF; dbus_we[k] = 1'b0; dbus_cyc[k] = 1'b0;
            sbus_adr[k] = '0; sbus_dat[k] = '0; sbus_sel[k] = 4'hF; sbus_we[k] = 1'b0; sbus_cyc[k] = 1'b0;
            ram_en[k]   = 1'b1;
        end
        rst = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_mem_cyc", k), mem_cyc[k], 0);
            chk($sformatf("rst%0d_owner", k),   owner[k],   0);
            chk($sformatf("rst%0d_timeout", k), timeout[k], 0);
            chk($sformatf("rst%0d_mem_sel", k), mem_sel[k], 0);
            chk($sformatf("rst%0d_ibus_rdt", k), ibus_rdt[k], 0);
        end
        tick();
        rst = 1'b0;

        // RR, all three requesting continuously
        tick();
        dbus_adr[0] = 32'h100;
        sbus_adr[0] = 32'h200;
        ibus_cyc[0] = 1'b1; dbus_cyc[0] = 1'b1; sbus_cyc[0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(0, P_I, 32'h13, 1'b0);
            push(0, P_D, 32'h113, 1'b0);
            push(0, P_S, 32'h213, 1'b0);
        end
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("rr_owner[%0d]", i), owner[0], rr_tbl[i]);
        end
        drain(0, 4);
        tick();
        ibus_cyc[0] = 1'b0; dbus_cyc[0] = 1'b0; sbus_cyc[0] = 1'b0;

        // Single ibus fetch
        tick();
        ibus_adr[0] = 32'h0;
        ibus_cyc[0] = 1'b1;
        push(0, P_I, 32'h00000013, 1'b0);
        @(negedge clk);
        chk("fetch_arb_latency_cyc", mem_cyc[0], 0);
        @(negedge clk);
        chk("fetch_mem_cyc", mem_cyc[0], 1);
        chk("fetch_owner",   owner[0],   P_I);
        chk("fetch_mem_sel", mem_sel[0], 4'hF);
        chk("fetch_mem_we",  mem_we[0],  0);
        chk("fetch_mem_dat", mem_dat[0], 0);
        drain(0, 5);
        tick();
        ibus_cyc[0] = 1'b0;
        @(negedge clk);
        chk("fetch_owner_after", owner[0], P_NONE);

        // dbus write mirrored onto the RAM port
        tick();
        dbus_adr[0] = 32'h100; dbus_dat[0] = 32'hCAFEBABE; dbus_sel[0] = 4'b0011;
        dbus_we[0]  = 1'b1;    dbus_cyc[0] = 1'b1;
        push(0, P_D, 32'h113, 1'b0);
        @(negedge clk);
        chk("wr_arb_latency_cyc", mem_cyc[0], 0);
        @(negedge clk);
        chk("wr_mem_adr", mem_adr[0], 32'h100);
        chk("wr_mem_dat", mem_dat[0], 32'hCAFEBABE);
        chk("wr_mem_sel", mem_sel[0], 4'b0011);
        chk("wr_mem_we",  mem_we[0],  1);
        chk("wr_mem_cyc", mem_cyc[0], 1);
        @(negedge clk);
        chk("wr_ibus_ack_quiet", ibus_ack[0], 0);
        chk("wr_sbus_ack_quiet", sbus_ack[0], 0);
        drain(0, 5);
        tick();
        dbus_cyc[0] = 1'b0; dbus_we[0] = 1'b0; dbus_sel[0] = 4'hF; dbus_dat[0] = 32'h0;

        // sbus read with a dead RAM: watchdog fires in the 8th busy cycle
        tick();
        ram_en[0]   = 1'b0;
        sbus_adr[0] = 32'h200;
        sbus_cyc[0] = 1'b1;
        push(0, P_S, 32'h0, 1'b1);
        @(negedge clk);
        repeat (7) @(negedge clk);
        chk("to_cycle7_mem_cyc", mem_cyc[0], 1);
        chk("to_cycle7_timeout", timeout[0], 0);
        @(negedge clk);
        chk("to_cycle8_mem_cyc_forced", mem_cyc[0], 0);
        chk("to_cycle8_owner",          owner[0],   P_S);
        drain(0, 2);
        tick();
        sbus_cyc[0] = 1'b0;
        ram_en[0]   = 1'b1;
        ibus_adr[0] = 32'h4;
        ibus_cyc[0] = 1'b1;
        push(0, P_I, 32'h17, 1'b0);
        drain(0, 10);
        tick();
        ibus_cyc[0] = 1'b0;

        // Abort: owner drops cyc mid-transaction
        ram_en[0]   = 1'b0;
        dbus_adr[0] = 32'h100;
        dbus_cyc[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_owner_busy", owner[0],   P_D);
        chk("abort_mem_cyc_up", mem_cyc[0], 1);
        tick();
        dbus_cyc[0] = 1'b0;
        @(negedge clk);
        chk("abort_mem_cyc_follows", mem_cyc[0],  0);
        chk("abort_no_ack",          dbus_ack[0], 0);
        @(negedge clk);
        chk("abort_owner_idle", owner[0], P_NONE);

        // Pointer unchanged by the abort: last completed was ibus, so dbus before sbus
        tick();
        ram_en[0]   = 1'b1;
        dbus_cyc[0] = 1'b1;
        sbus_cyc[0] = 1'b1;
        push(0, P_D, 32'h113, 1'b0);
        push(0, P_S, 32'h213, 1'b0);
        drain(0, 20);
        tick();
        dbus_cyc[0] = 1'b0;
        sbus_cyc[0] = 1'b0;

        // Asynchronous reset in the middle of a transaction
        tick();
        ram_en[0]   = 1'b0;
        ibus_adr[0] = 32'h0;
        ibus_cyc[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_owner_before", owner[0], P_I);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid_mem_cyc", mem_cyc[0],  0);
        chk("rstmid_owner",   owner[0],    P_NONE);
        chk("rstmid_no_ack",  ibus_ack[0], 0);
        tick();
        rst         = 1'b0;
        ibus_cyc[0] = 1'b0;
        ram_en[0]   = 1'b1;

        // FIXED priority: sbus dominates, then dbus, then ibus
        tick();
        ibus_adr[1] = 32'h0; dbus_adr[1] = 32'h100; sbus_adr[1] = 32'h200;
        ibus_cyc[1] = 1'b1;  dbus_cyc[1] = 1'b1;    sbus_cyc[1] = 1'b1;
        repeat (3) push(1, P_S, 32'h213, 1'b0);
        drain(1, 30);
        tick();
        sbus_cyc[1] = 1'b0;
        push(1, P_D, 32'h113, 1'b0);
        drain(1, 10);
        tick();
        dbus_cyc[1] = 1'b0;
        push(1, P_I, 32'h13, 1'b0);
        drain(1, 10);
        tick();
        ibus_cyc[1] = 1'b0;

        repeat (4) @(negedge clk);
        chk("end_sb0_empty", sb0.size(), 0);
        chk("end_sb1_empty", sb1.size(), 0);
        chk("end_owner0", owner[0], P_NONE);
        chk("end_owner1", owner[1], P_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_servant_ram_arbiter
`default_nettype wire
